wb_uart_tx_arbiter: RTL and testbench
=====================================

// Module: wb_uart_tx_arbiter
//
// PURPOSE
// - Shares one wb_uart_tx transmitter between N_PORTS Wishbone-style byte requesters.
// - Round-robin grant, one byte per grant.
// - Paces writes by counting the transmitter's frame time: 1 start + 8 data + 1 stop, each
//   TICKS_PER_BAUD cycles. The transmitter has no busy output.
// - Sits between the CPU/peripheral masters and the single wb_uart_tx instance.
//
// PARAMETERS
// - N_PORTS        4  number of requesters, 2..8
// - TICKS_PER_BAUD 8  clock cycles per UART bit; must equal the transmitter's setting
//
// PORTS
// - wb_clk_i   in   1            single clock
// - wb_rst_ni  in   1            asynchronous reset, active-low
// - req_stb_i  in   N_PORTS      per-port byte request; bit p = port p
// - req_dat_i  in   8*N_PORTS    per-port byte; port p at [8p+7:8p]
// - req_ack_o  out  N_PORTS      one-cycle acknowledge, byte taken
// - tx_stb_o   out  1            to wb_uart_tx wb_stb_i
// - tx_dat_o   out  8            to wb_uart_tx wb_dat_i
// - tx_rst_o   out  1            active-high reset for wb_uart_tx = !wb_rst_ni
// - busy_o     out  1            frame in flight
//
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE, rr_ptr=0, timer=0.
//   All outputs 0 except tx_rst_o=1.
// - FRAME_CYCLES = 10*TICKS_PER_BAUD. Timer width = clog2(FRAME_CYCLES+1).
// - IDLE:
//   - if any req_stb_i, pick grant g = first set bit at or after rr_ptr, wrapping N_PORTS-1 -> 0.
//   - Register g and req_dat_i[g]; go to ISSUE.
//   - Otherwise stay in IDLE.
// - ISSUE (exactly 1 cycle):
//   - tx_stb_o=1, tx_dat_o=latched byte, req_ack_o[g]=1 (only bit set).
//   - rr_ptr <= (g+1) mod N_PORTS; timer <= FRAME_CYCLES; go to WAIT.
// - WAIT:
//   - timer decrements each cycle.
//   - When timer==1, go to IDLE. Earliest next ISSUE is FRAME_CYCLES+2 cycles after the
//     previous ISSUE: one guard cycle past the transmitter's return to idle.
// - busy_o=1 in ISSUE and WAIT.
// - tx_stb_o=0 and tx_dat_o=0 outside ISSUE; all req_ack_o bits 0 outside ISSUE.
// - Latency: request seen in IDLE at cycle t -> ack/tx_stb_o at t+1 (registered).
// - Requesters hold req_stb_i/req_dat_i stable until ack.
//   - Data is sampled at the IDLE->ISSUE edge.
//   - If stb is dropped after that sample, the byte is still sent and acked.
// - Requests arriving during ISSUE/WAIT are ignored until IDLE; no queuing, no lost grant state.
// - Simultaneous requests: rr_ptr order; a port that was just granted has lowest priority next time.
// - Single persistent requester: granted back-to-back at maximum frame rate.
// - Reset mid-frame: arbiter returns to IDLE immediately and tx_rst_o resets the transmitter.
//   No ack is issued for an interrupted grant. The byte in flight is truncated; the line returns
//   to idle.
// - No combinational path from req_* to any output.
//
// STRUCTURE
// - Shared package wb_uart_pkg holds:
//   - state encoding: IDLE=0, ISSUE=1, WAIT=2 (2 bits)
//   - UART_FRAME_BITS=10 (start+8+stop)
//   - helper function frame_cycles(ticks)
// - One sub-module, wb_rr_arbiter #(N):
//   - combinational pick of g from req vector and pointer, plus a valid flag
//   - reusable by other shared peripherals
// - Top holds the FSM, frame timer, data latch and pointer.
//
// TESTING
// - Reset, no requests -> tx_stb_o=0, busy_o=0, req_ack_o=0, tx_rst_o=1 while wb_rst_ni=0.
// - Port 2 requests 0x55 at cycle t -> req_ack_o=4'b0100 and tx_stb_o=1, tx_dat_o=0x55 at t+1.
//   Decoded serial line on wb_uart_tx = start, 1,0,1,0,1,0,1,0, stop.
// - Ports 0,1,3 request together, rr_ptr=0 -> grants 0,1,3 in order.
//   tx_stb_o pulses exactly 82 cycles apart (TICKS=8); each ack once.
// - Port 1 held continuously with 0xA5 while port 0 pulses after the first grant -> grants alternate 1,0,1.
//   No two tx_stb_o pulses less than FRAME_CYCLES+2 cycles apart.
// - wb_rst_ni low at the 30th cycle of WAIT -> same cycle: busy_o=0, tx_rst_o=1.
//   After release, the first pending request issues 1 cycle after IDLE samples it.
// - Byte changes after the sample edge (0x12 -> 0x34 during ISSUE) -> 0x12 transmitted.
//   Formal: onehot0(req_ack_o), tx_stb_o -> busy_o.

Source files
------------

// File: rtl/wb_uart_pkg.sv
// Shared definitions for the Wishbone UART transmit path: arbiter FSM encoding and
// serial frame geometry.
package wb_uart_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   // One start bit, eight data bits, one stop bit.
   localparam int UART_FRAME_BITS = 10;

   function automatic int frame_cycles(input int ticks);
      return UART_FRAME_BITS * ticks;
   endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping N-1 -> 0.
// Generic so other shared peripherals can reuse it.
module wb_rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [$clog2(N)-1:0] grant,
   output logic                 valid
);

   localparam int PW = $clog2(N);

   int            idx;
   logic [PW-1:0] sel;

   // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = 0;
      sel   = '0;
      // Walk from the farthest offset to the nearest so the nearest set bit wins.
      for (int i = N - 1; i >= 0; i--) begin
         idx = int'(ptr) + i;
         if (idx >= N) idx = idx - N;
         sel = PW'(idx);
         if (req[sel]) begin
            grant = sel;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_uart_tx_arbiter.sv
// Shares one wb_uart_tx between N_PORTS byte requesters: round-robin, one byte per grant,
// writes paced by counting the transmitter's frame time since it has no busy output.
module wb_uart_tx_arbiter
   import wb_uart_pkg::*;
#(
   parameter int N_PORTS        = 4,
   parameter int TICKS_PER_BAUD = 8
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_ni,
   input  logic [N_PORTS-1:0]   req_stb_i,
   input  logic [8*N_PORTS-1:0] req_dat_i,
   output logic [N_PORTS-1:0]   req_ack_o,
   output logic                 tx_stb_o,
   output logic [7:0]           tx_dat_o,
   output logic                 tx_rst_o,
   output logic                 busy_o
);

   localparam int FRAME_CYCLES = frame_cycles(TICKS_PER_BAUD);
   localparam int TW           = $clog2(FRAME_CYCLES + 1);
   localparam int PW           = $clog2(N_PORTS);

   logic [1:0]    state;
   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] grant_q;
   logic [7:0]    dat_q;
   logic [TW-1:0] timer;

   logic [PW-1:0] pick;
   logic          pick_valid;
   logic [7:0]    pick_dat;

   wb_rr_arbiter #(
      .N (N_PORTS)
   ) u_rr (
      .req   (req_stb_i),
      .ptr   (rr_ptr),
      .grant (pick),
      .valid (pick_valid)
   );

   always_comb begin
      pick_dat = '0;
      for (int p = 0; p < N_PORTS; p++) begin
         if (pick == PW'(p)) pick_dat = req_dat_i[8*p +: 8];
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state   <= ST_IDLE;
         rr_ptr  <= '0;
         grant_q <= '0;
         dat_q   <= '0;
         timer   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  grant_q <= pick;
                  dat_q   <= pick_dat;
                  state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               rr_ptr <= (grant_q == PW'(N_PORTS - 1)) ? '0 : grant_q + 1'b1;
               timer  <= TW'(FRAME_CYCLES);
               state  <= ST_WAIT;
            end
            ST_WAIT: begin
               timer <= timer - 1'b1;
               // Leaving at timer==1 adds one guard cycle past the transmitter's stop bit.
               if (timer == TW'(1)) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Outputs decode registered state only; no path from req_* reaches them.
   assign tx_rst_o = !wb_rst_ni;
   assign busy_o   = (state == ST_ISSUE) || (state == ST_WAIT);
   assign tx_stb_o = (state == ST_ISSUE);
   assign tx_dat_o = tx_stb_o ? dat_q : 8'h00;

   always_comb begin
      req_ack_o = '0;
      if (tx_stb_o) req_ack_o[grant_q] = 1'b1;
   end

endmodule

// File: tb/tb_wb_uart_tx_arbiter.sv
// Bench for wb_uart_tx_arbiter: scoreboard of expected grants, a reference serial
// transmitter driven by tx_stb_o/tx_dat_o, and a line decoder.
module tb_wb_uart_tx_arbiter;

   localparam int N     = 4;
   localparam int TICKS = 8;
   localparam int FRAME = 10 * TICKS;
   localparam int GAP   = FRAME + 2;

   typedef struct {
      int         port;
      logic [7:0] data;
   } exp_t;

   logic           clk   = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   stb   = '0;
   logic [8*N-1:0] dat   = '0;
   logic [N-1:0]   ack;
   logic           tx_stb;
   logic [7:0]     tx_dat;
   logic           tx_rst;
   logic           busy;

   int           total = 0;
   int           bad   = 0;
   int           cyc   = 0;
   int           last_stb = -1;
   exp_t         sb[$];
   int           stb_cyc[$];
   int           ack_cnt[N];
   logic [N-1:0] drop_mask = '0;

   wb_uart_tx_arbiter #(
      .N_PORTS        (N),
      .TICKS_PER_BAUD (TICKS)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .req_stb_i (stb),
      .req_dat_i (dat),
      .req_ack_o (ack),
      .tx_stb_o  (tx_stb),
      .tx_dat_o  (tx_dat),
      .tx_rst_o  (tx_rst),
      .busy_o    (busy)
   );

   always #5 clk = ~clk;

   // Reference transmitter: 10-bit frame, LSB first, TICKS cycles per bit, no busy output.
   logic [9:0] shreg = '1;
   int         bits_left = 0;
   int         tick_cnt = 0;
   int         overlap_err = 0;
   logic       line;
   assign line = shreg[0];

   always @(posedge clk or posedge tx_rst) begin
      if (tx_rst) begin
         shreg     <= '1;
         bits_left <= 0;
         tick_cnt  <= 0;
      end else if (tx_stb) begin
         if (bits_left != 0) overlap_err <= overlap_err + 1;
         shreg     <= {1'b1, tx_dat, 1'b0};
         bits_left <= 10;
         tick_cnt  <= TICKS - 1;
      end else if (bits_left != 0) begin
         if (tick_cnt == 0) begin
            shreg     <= {1'b1, shreg[9:1]};
            bits_left <= bits_left - 1;
            tick_cnt  <= TICKS - 1;
         end else begin
            tick_cnt <= tick_cnt - 1;
         end
      end
   end

   logic [7:0] rx_bytes [0:63];
   int         rx_cnt = 0;

   initial begin : decoder
      logic [7:0] b;
      b = '0;
      forever begin
         @(negedge line);
         repeat (TICKS / 2) @(negedge clk);
         if (line == 1'b0) begin
            for (int i = 0; i < 8; i++) begin
               repeat (TICKS) @(negedge clk);
               b[i] = line;
            end
            repeat (TICKS) @(negedge clk);
            if (line == 1'b1 && rx_cnt < 64) begin
               rx_bytes[rx_cnt] = b;
               rx_cnt++;
            end
         end
      end
   end

   // One clock, then per-cycle invariants and scoreboard pop on every tx_stb pulse.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      total++;
      if ((ack & (ack - 1'b1)) !== '0) begin
         bad++;
         $display("FAIL ack_onehot0: ack=%b required at most one bit set", ack);
      end
      total++;
      if (tx_stb === 1'b1 && busy !== 1'b1) begin
         bad++;
         $display("FAIL stb_implies_busy: busy=%b required 1 while tx_stb=1", busy);
      end
      if (tx_stb !== 1'b1) begin
         total++;
         if (ack !== '0 || tx_dat !== 8'h00) begin
            bad++;
            $display("FAIL idle_outputs: ack=%b tx_dat=%h required 0000/00", ack, tx_dat);
         end
      end else begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_stb: tx_dat=%h ack=%b required no pulse", tx_dat, ack);
         end else begin
            e = sb.pop_front();
            if (ack !== (4'b0001 << e.port) || tx_dat !== e.data) begin
               bad++;
               $display("FAIL grant: ack=%b tx_dat=%h required port %0d data %h",
                        ack, tx_dat, e.port, e.data);
            end
         end
         if (last_stb >= 0) begin
            total++;
            if (cyc - last_stb < GAP) begin
               bad++;
               $display("FAIL stb_spacing: gap=%0d required >= %0d", cyc - last_stb, GAP);
            end
         end
         last_stb = cyc;
         stb_cyc.push_back(cyc);
         for (int p = 0; p < N; p++) if (ack[p]) ack_cnt[p]++;
      end
      stb = stb & ~(ack & drop_mask);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 200) begin
         tick();
         n++;
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL %s: busy=%b required 0 within 200 cycles", name, busy);
      end
   endtask

   task automatic wait_rx(input int idx, input logic [7:0] exp_byte, input string name);
      int n;
      n = 0;
      while (rx_cnt <= idx && n < 300) begin
         tick();
         n++;
      end
      total++;
      if (rx_cnt <= idx) begin
         bad++;
         $display("FAIL %s: no frame decoded, required %h", name, exp_byte);
      end else if (rx_bytes[idx] !== exp_byte) begin
         bad++;
         $display("FAIL %s: line byte=%h required %h", name, rx_bytes[idx], exp_byte);
      end
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      stb      = '0;
      last_stb = -1;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      stb   = '0;
      repeat (2) tick();
      total++;
      if (tx_stb !== 1'b0 || busy !== 1'b0 || ack !== '0 || tx_rst !== 1'b1 || tx_dat !== 8'h00) begin
         bad++;
         $display("FAIL reset_outputs: stb=%b busy=%b ack=%b rst=%b dat=%h required 0 0 0000 1 00",
                  tx_stb, busy, ack, tx_rst, tx_dat);
      end
      rst_n = 1'b1;
      tick();
      total++;
      if (tx_rst !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: tx_rst=%b busy=%b required 0 0", tx_rst, busy);
      end
   endtask

   task automatic test_single();
      int rx0;
      rx0       = rx_cnt;
      drop_mask = '1;
      dat[23:16] = 8'h55;
      stb[2]     = 1'b1;
      sb.push_back('{2, 8'h55});
      tick();
      total++;
      if (tx_stb !== 1'b1 || ack !== 4'b0100 || tx_dat !== 8'h55) begin
         bad++;
         $display("FAIL single_latency: stb=%b ack=%b dat=%h required 1 0100 55", tx_stb, ack, tx_dat);
      end
      wait_rx(rx0, 8'h55, "single_serial");
      wait_idle("single_idle");
   endtask

   task automatic test_simultaneous();
      int n0;
      int n;
      do_reset();
      n0        = stb_cyc.size();
      ack_cnt   = '{default: 0};
      drop_mask = '1;
      dat[7:0]   = 8'h11;
      dat[15:8]  = 8'h22;
      dat[31:24] = 8'h44;
      stb        = 4'b1011;
      sb.push_back('{0, 8'h11});
      sb.push_back('{1, 8'h22});
      sb.push_back('{3, 8'h44});
      n = 0;
      while (stb_cyc.size() < n0 + 3 && n < 400) begin
         tick();
         n++;
      end
      total++;
      if (stb_cyc.size() < n0 + 3) begin
         bad++;
         $display("FAIL simul_timeout: pulses=%0d required 3", stb_cyc.size() - n0);
      end else begin
         for (int k = 0; k < 2; k++) begin
            total++;
            if (stb_cyc[n0+k+1] - stb_cyc[n0+k] !== GAP) begin
               bad++;
               $display("FAIL simul_gap%0d: gap=%0d required %0d", k,
                        stb_cyc[n0+k+1] - stb_cyc[n0+k], GAP);
            end
         end
      end
      wait_idle("simul_idle");
      repeat (10) tick();
      for (int p = 0; p < N; p++) begin
         total++;
         if (ack_cnt[p] !== ((p == 2) ? 0 : 1)) begin
            bad++;
            $display("FAIL simul_ack_count port%0d: acks=%0d required %0d", p, ack_cnt[p],
                     (p == 2) ? 0 : 1);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n0;
      int n;
      bit raised;
      n0        = stb_cyc.size();
      drop_mask = 4'b1101;
      dat[15:8] = 8'hA5;
      stb[1]    = 1'b1;
      sb.push_back('{1, 8'hA5});
      raised = 1'b0;
      n      = 0;
      while (stb_cyc.size() < n0 + 3 && n < 400) begin
         tick();
         n++;
         if (!raised && ack[1] === 1'b1) begin
            raised   = 1'b1;
            dat[7:0] = 8'h0F;
            stb[0]   = 1'b1;
            sb.push_back('{0, 8'h0F});
            sb.push_back('{1, 8'hA5});
         end
      end
      stb[1] = 1'b0;
      total++;
      if (stb_cyc.size() < n0 + 3) begin
         bad++;
         $display("FAIL b2b_timeout: pulses=%0d required 3", stb_cyc.size() - n0);
      end else begin
         for (int k = 0; k < 2; k++) begin
            total++;
            if (stb_cyc[n0+k+1] - stb_cyc[n0+k] !== GAP) begin
               bad++;
               $display("FAIL b2b_gap%0d: gap=%0d required %0d", k,
                        stb_cyc[n0+k+1] - stb_cyc[n0+k], GAP);
            end
         end
      end
      wait_idle("b2b_idle");
   endtask

   task automatic test_reset_mid_frame();
      drop_mask  = '1;
      dat[31:24] = 8'h3C;
      stb[3]     = 1'b1;
      sb.push_back('{3, 8'h3C});
      tick();
      total++;
      if (tx_stb !== 1'b1) begin
         bad++;
         $display("FAIL midrst_issue: stb=%b required 1", tx_stb);
      end
      repeat (30) tick();
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL midrst_busy_before: busy=%b required 1", busy);
      end
      dat[7:0] = 8'h99;
      stb[0]   = 1'b1;
      rst_n    = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || tx_rst !== 1'b1 || tx_stb !== 1'b0 || ack !== '0) begin
         bad++;
         $display("FAIL midrst_same_cycle: busy=%b tx_rst=%b stb=%b ack=%b required 0 1 0 0000",
                  busy, tx_rst, tx_stb, ack);
      end
      last_stb = -1;
      repeat (2) tick();
      rst_n = 1'b1;
      sb.push_back('{0, 8'h99});
      tick();
      total++;
      if (tx_stb !== 1'b1 || ack !== 4'b0001 || tx_dat !== 8'h99) begin
         bad++;
         $display("FAIL midrst_after_release: stb=%b ack=%b dat=%h required 1 0001 99",
                  tx_stb, ack, tx_dat);
      end
      wait_idle("midrst_idle");
      repeat (150) tick();
   endtask

   task automatic test_data_change();
      int rx0;
      int n0;
      int n;
      rx0       = rx_cnt;
      n0        = stb_cyc.size();
      drop_mask = '1;
      dat[15:8] = 8'h12;
      stb[1]    = 1'b1;
      sb.push_back('{1, 8'h12});
      tick();
      total++;
      if (tx_dat !== 8'h12) begin
         bad++;
         $display("FAIL change_issue: tx_dat=%h required 12", tx_dat);
      end
      dat[15:8] = 8'h34;
      repeat (10) tick();
      dat[23:16] = 8'h77;
      stb[2]     = 1'b1;
      sb.push_back('{2, 8'h77});
      n = 0;
      while (stb_cyc.size() < n0 + 2 && n < 200) begin
         tick();
         n++;
      end
      total++;
      if (stb_cyc.size() < n0 + 2) begin
         bad++;
         $display("FAIL change_timeout: pulses=%0d required 2", stb_cyc.size() - n0);
      end else if (stb_cyc[n0+1] - stb_cyc[n0] !== GAP) begin
         bad++;
         $display("FAIL change_wait_ignored: gap=%0d required %0d", stb_cyc[n0+1] - stb_cyc[n0], GAP);
      end
      wait_rx(rx0, 8'h12, "change_serial");
      wait_rx(rx0 + 1, 8'h77, "late_req_serial");
      wait_idle("change_idle");
   endtask

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid_frame();
      test_data_change();
      repeat (20) tick();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover: pending=%0d required 0", sb.size());
      end
      total++;
      if (overlap_err != 0) begin
         bad++;
         $display("FAIL tx_overlap: overlaps=%0d required 0", overlap_err);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
